// File: rtl/mem_resp_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp_stage
// Purpose  : Memory-access pipeline stage between execute and write-back.
//            Accepts one instruction per handshake, waits for the data-SRAM
//            response on loads/stores, extracts and extends load data and
//            presents the write-back bus. A response that arrives while
//            write-back back-pressures is held until write-back accepts.
// Revision : 1.0 - initial release
//
// Ports
//   clk             clock
//   resetn          asynchronous, active-low reset
//   es_to_ms_valid  execute stage holds a valid instruction
//   es_to_ms_bus    {mem_we, res_from_mem, ld_type[2:0], gr_we, dest[4:0],
//                    alu_result[31:0], pc[31:0]}
//   ms_allowin      this stage accepts a new instruction this cycle
//   ws_allowin      write-back stage accepts
//   ms_to_ws_valid  write-back bus is valid
//   ms_to_ws_bus    {gr_we, dest[4:0], final_result[31:0], pc[31:0]}
//   data_data_ok    one-cycle data-SRAM response pulse
//   data_rdata      load data, valid with data_data_ok
//   ms_to_ds_bus    (MS_FWD_EN only) {ms_valid&gr_we, ms_data_pending,
//                    dest[4:0], final_result[31:0]} for decode bypass/stall
//
// Optional feature macro: MS_FWD_EN
// ============================================================================
module mem_resp_stage #(
    parameter int ES_BUS_WD = 75,
    parameter int WS_BUS_WD = 70
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 es_to_ms_valid,
    input  logic [ES_BUS_WD-1:0] es_to_ms_bus,
    output logic                 ms_allowin,
    input  logic                 ws_allowin,
    output logic                 ms_to_ws_valid,
    output logic [WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                 data_data_ok,
`ifdef MS_FWD_EN
    input  logic [31:0]          data_rdata,
    output logic [38:0]          ms_to_ds_bus
`else
    input  logic [31:0]          data_rdata
`endif
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_HELD = 2'd2;

    logic                 r_ms_valid;
    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [ES_BUS_WD-1:0] r_bus;
    logic [31:0]          r_held;

    // Fields of the latched instruction
    logic        w_mem_we;
    logic        w_res_from_mem;
    logic [2:0]  w_ld_type;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_alu_result;
    logic [31:0] w_pc;

    assign w_mem_we       = r_bus[74];
    assign w_res_from_mem = r_bus[73];
    assign w_ld_type      = r_bus[72:70];
    assign w_gr_we        = r_bus[69];
    assign w_dest         = r_bus[68:64];
    assign w_alu_result   = r_bus[63:32];
    assign w_pc           = r_bus[31:0];

    logic w_need_resp;
    logic w_ready_go;
    logic w_accept;
    logic w_new_need_resp;
    logic w_capture;

    assign w_need_resp = r_ms_valid & (w_mem_we | w_res_from_mem);

    // A response arriving in WAIT forwards combinationally in the same cycle.
    assign w_ready_go = r_ms_valid &
                        (~w_need_resp | (r_state == c_HELD) |
                         ((r_state == c_WAIT) & data_data_ok));

    assign ms_allowin     = ~r_ms_valid | (w_ready_go & ws_allowin);
    assign ms_to_ws_valid = r_ms_valid & w_ready_go;

    assign w_accept        = es_to_ms_valid & ms_allowin;
    assign w_new_need_resp = es_to_ms_bus[74] | es_to_ms_bus[73];

    // Only a response for the current instruction is captured; pulses seen
    // in IDLE or HELD are stale and dropped.
    assign w_capture = (r_state == c_WAIT) & data_data_ok & ~ws_allowin;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= c_IDLE;
            r_ms_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = w_new_need_resp ? c_WAIT : c_IDLE;
        end else if (ms_allowin) begin
            // Stage drains (or was already empty) with nothing new arriving.
            w_state_nxt = c_IDLE;
        end else if (w_capture) begin
            w_state_nxt = c_HELD;
        end
    end

    // ------------------------------------------------------------------
    // Data registers: contents are meaningless while the stage is invalid,
    // so they carry no reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_bus <= es_to_ms_bus;
        end
        if (w_capture) begin
            r_held <= data_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Load extraction
    // ------------------------------------------------------------------
    logic [31:0] w_rdata_sel;
    logic [1:0]  w_off;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;
    logic [31:0] w_final_result;

    assign w_rdata_sel = (r_state == c_HELD) ? r_held : data_rdata;
    assign w_off       = w_alu_result[1:0];

    always_comb begin
        w_byte = w_rdata_sel[7:0];
        case (w_off)
            2'd0:    w_byte = w_rdata_sel[7:0];
            2'd1:    w_byte = w_rdata_sel[15:8];
            2'd2:    w_byte = w_rdata_sel[23:16];
            default: w_byte = w_rdata_sel[31:24];
        endcase
    end

    // Halfword lane chosen by off[1]; off[0] is ignored (no alignment check).
    assign w_half = w_off[1] ? w_rdata_sel[31:16] : w_rdata_sel[15:0];

    always_comb begin
        w_load_val = w_rdata_sel;
        case (w_ld_type)
            3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_val = {24'd0, w_byte};
            3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_val = {16'd0, w_half};
            default: w_load_val = w_rdata_sel;
        endcase
    end

    assign w_final_result = w_res_from_mem ? w_load_val : w_alu_result;

    assign ms_to_ws_bus = {w_gr_we, w_dest, w_final_result, w_pc};

`ifdef MS_FWD_EN
    logic w_data_pending;

    // Decode must stall on a load whose data is not yet available.
    assign w_data_pending = r_ms_valid & w_res_from_mem & ~w_ready_go;
    assign ms_to_ds_bus   = {r_ms_valid & w_gr_we, w_data_pending, w_dest,
                             w_final_result};
`endif

endmodule
`default_nettype wire
